// File: rtl/button_conditioner.sv
// Push-button front end for the stopwatch: synchronizes, debounces and turns
// presses on start/stop/inc into one-cycle command pulses, with inc auto-repeat.
//
// state  | meaning
// IDLE   | no repeat pending; waits for a fresh inc press
// DELAY  | inc held with repeat enabled; counting to the first repeat
// REPEAT | inc still held; emitting a repeat pulse every REPEAT_PERIOD
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000,
   parameter int CNT_W           = 26
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_stop,
   input  logic       btn_inc,
   input  logic       repeat_en,
   output logic       start,
   output logic       stop,
   output logic       inc,
   output logic [2:0] held
);

   localparam logic [CNT_W-1:0] DB_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DLY_TC = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_TC = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DELAY  = 2'd1;
   localparam logic [1:0] REPEAT = 2'd2;

   logic [2:0]       btn_raw;
   logic [2:0]       sync1_q, sync2_q, stable_q, stable_dly_q;
   logic [CNT_W-1:0] db_cnt_q [3];
   logic [2:0]       rise;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             inc_d;
   logic             start_q, stop_q, inc_q;

   // bit order {inc, stop, start} throughout
   assign btn_raw = {btn_inc, btn_stop, btn_start};
   assign rise    = stable_q & ~stable_dly_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         stable_q     <= '0;
         stable_dly_q <= '0;
         for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q      <= btn_raw;
         sync2_q      <= sync1_q;
         stable_dly_q <= stable_q;
         for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DB_TC) begin
               stable_q[i] <= sync2_q[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + ONE;
            end
         end
      end
   end

   // Leaving DELAY/REPEAT takes priority over a terminal-count pulse.
   always_comb begin
      state_d   = state_q;
      rep_cnt_d = rep_cnt_q;
      inc_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise[2]) begin
               inc_d = 1'b1;
               if (repeat_en) begin
                  state_d   = DELAY;
                  rep_cnt_d = '0;
               end
            end
         end
         DELAY: begin
            if (!stable_q[2] || !repeat_en) begin
               state_d   = IDLE;
               rep_cnt_d = '0;
            end else if (rep_cnt_q == DLY_TC) begin
               inc_d     = 1'b1;
               rep_cnt_d = '0;
               state_d   = REPEAT;
            end else begin
               rep_cnt_d = rep_cnt_q + ONE;
            end
         end
         REPEAT: begin
            if (!stable_q[2] || !repeat_en) begin
               state_d   = IDLE;
               rep_cnt_d = '0;
            end else if (rep_cnt_q == PER_TC) begin
               inc_d     = 1'b1;
               rep_cnt_d = '0;
            end else begin
               rep_cnt_d = rep_cnt_q + ONE;
            end
         end
         default: begin
            state_d   = IDLE;
            rep_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         rep_cnt_q <= '0;
         start_q   <= 1'b0;
         stop_q    <= 1'b0;
         inc_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rep_cnt_q <= rep_cnt_d;
         start_q   <= rise[0] & ~rise[1];
         stop_q    <= rise[1];
         inc_q     <= inc_d;
      end
   end

   assign start = start_q;
   assign stop  = stop_q;
   assign inc   = inc_q;
   assign held  = stable_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button activity,
// compared every cycle against a run-length / due-time reference model.
module tb_button_conditioner;

   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RP = 5;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       btn_start = 1'b0, btn_stop = 1'b0, btn_inc = 1'b0, repeat_en = 1'b0;
   logic       start, stop, inc;
   logic [2:0] held;

   always #5 clock = ~clock;

   button_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP),
      .CNT_W(8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .btn_start(btn_start),
      .btn_stop(btn_stop),
      .btn_inc(btn_inc),
      .repeat_en(repeat_en),
      .start(start),
      .stop(stop),
      .inc(inc),
      .held(held)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
      end
   endtask

   // reference model: raw samples from one and two edges back, per-button
   // run length of disagreeing samples, and the absolute cycle of the next repeat
   logic [2:0] m_prev1, m_prev2, m_stab, m_rose;
   int         m_run [3];
   int         m_due;
   int         cyc = 0;

   int edge_no;
   int n_st, n_sp, n_in, last_st, last_sp, last_in;

   task automatic model_reset();
      m_prev1 = '0;
      m_prev2 = '0;
      m_stab  = '0;
      m_rose  = '0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
      m_due = -1;
   endtask

   task automatic mark();
      edge_no = 0;
      n_st = 0; n_sp = 0; n_in = 0;
      last_st = -1; last_sp = -1; last_in = -1;
   endtask

   task automatic step();
      logic [2:0] r, seen, new_rose;
      logic       ren, e_st, e_sp, e_in;
      @(posedge clock);
      r    = {btn_inc, btn_stop, btn_start};
      ren  = repeat_en;
      seen = m_prev2;
      e_st = m_rose[0] & ~m_rose[1];
      e_sp = m_rose[1];
      e_in = 1'b0;
      if (m_rose[2]) begin
         e_in  = 1'b1;
         m_due = ren ? cyc + RD : -1;
      end else if (m_due >= 0) begin
         if (!m_stab[2] || !ren) m_due = -1;
         else if (cyc == m_due) begin
            e_in  = 1'b1;
            m_due = cyc + RP;
         end
      end
      new_rose = '0;
      for (int i = 0; i < 3; i++) begin
         if (seen[i] != m_stab[i]) begin
            m_run[i]++;
            if (m_run[i] == D) begin
               m_stab[i]   = seen[i];
               m_run[i]    = 0;
               new_rose[i] = seen[i];
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_rose  = new_rose;
      m_prev2 = m_prev1;
      m_prev1 = r;
      #1;
      chk("start", {31'd0, start}, {31'd0, e_st});
      chk("stop", {31'd0, stop}, {31'd0, e_sp});
      chk("inc", {31'd0, inc}, {31'd0, e_in});
      chk("held", {29'd0, held}, {29'd0, m_stab});
      if (start) begin n_st++; last_st = edge_no; end
      if (stop)  begin n_sp++; last_sp = edge_no; end
      if (inc)   begin n_in++; last_in = edge_no; end
      edge_no++;
      cyc++;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_start", {31'd0, start}, 32'd0);
      chk("rst_stop", {31'd0, stop}, 32'd0);
      chk("rst_inc", {31'd0, inc}, 32'd0);
      chk("rst_held", {29'd0, held}, 32'd0);
      model_reset();
      @(negedge clock);
      reset = 1'b0;
   endtask

   int         hold [3];
   logic [2:0] lvl;

   initial begin
      model_reset();
      mark();
      #2;
      chk("por_held", {29'd0, held}, 32'd0);
      chk("por_start", {31'd0, start}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      run(3);

      // clean start press, then release
      mark(); btn_start = 1'b1; run(20);
      btn_start = 1'b0; run(10);
      chk("clean_start_cnt", n_st, 1);
      chk("clean_start_edge", last_st, 6);

      // bouncing stop, then held
      mark();
      for (int k = 0; k < 12; k++) begin
         btn_stop = ((k / 2) % 2 == 0);
         step();
      end
      btn_stop = 1'b1; run(12);
      chk("bounce_stop_cnt", n_sp, 1);
      chk("bounce_stop_edge", last_sp, 18);
      btn_stop = 1'b0; run(10);

      // simultaneous start and stop
      mark(); btn_start = 1'b1; btn_stop = 1'b1; run(15);
      chk("simul_stop_cnt", n_sp, 1);
      chk("simul_stop_edge", last_sp, 6);
      chk("simul_start_cnt", n_st, 0);
      btn_start = 1'b0; btn_stop = 1'b0; run(10);

      // auto-repeat held for 40 clocks
      mark(); repeat_en = 1'b1; btn_inc = 1'b1; run(40);
      chk("rep_cnt", n_in, 6);
      chk("rep_last", last_in, 36);
      btn_inc = 1'b0; run(10);

      // auto-repeat with repeat_en dropped after edge 23
      mark(); btn_inc = 1'b1; run(24);
      repeat_en = 1'b0; run(16);
      chk("repdrop_cnt", n_in, 3);
      chk("repdrop_last", last_in, 21);
      btn_inc = 1'b0; run(10);

      // repeat disabled
      mark(); btn_inc = 1'b1; run(40);
      chk("norep_cnt", n_in, 1);
      chk("norep_edge", last_in, 6);
      btn_inc = 1'b0; run(10);

      // reset mid-press with all buttons held through release
      btn_start = 1'b1; btn_stop = 1'b1; btn_inc = 1'b1; run(4);
      do_reset();
      mark(); run(12);
      chk("rstpress_start_cnt", n_st, 0);
      chk("rstpress_stop_cnt", n_sp, 1);
      chk("rstpress_stop_edge", last_sp, 6);
      chk("rstpress_inc_cnt", n_in, 1);
      chk("rstpress_inc_edge", last_in, 6);
      btn_start = 1'b0; btn_stop = 1'b0; btn_inc = 1'b0; run(10);

      // random activity
      for (int i = 0; i < 3; i++) hold[i] = 0;
      lvl = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 3; i++) begin
            if (hold[i] == 0) begin
               lvl[i]  = 1'($urandom_range(0, 1));
               hold[i] = $urandom_range(1, 25);
            end else begin
               hold[i]--;
            end
         end
         btn_start = lvl[0];
         btn_stop  = lvl[1];
         btn_inc   = lvl[2];
         if ($urandom_range(0, 39) == 0) repeat_en = ~repeat_en;
         if ($urandom_range(0, 499) == 0) do_reset();
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
